// File: rtl/wdt_pkg.sv
// Shared register map, bit positions and controller state encoding for the
// watchdog interface controller.
package wdt_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_KICK   = 4'h4;
    localparam logic [3:0] ADDR_TOCNT  = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IE_BIT     = 1;
    localparam int unsigned STATUS_TO_BIT   = 0;
    localparam int unsigned STATUS_BUSY_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KICK = 2'd1,
        ST_LOAD = 2'd2
    } wdt_state_e;

endpackage

// File: rtl/wdt_sync.sv
// Multi-flop synchronizer for an asynchronous level, followed by a
// single-cycle rising-edge detector on the synchronized signal.
module wdt_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/wdt_ctrl.sv
// Register-mapped watchdog controller: CTRL/KICK/TOCNT/STATUS registers, a
// kick/load hold sequencer and a synchronized timeout interrupt.
module wdt_ctrl
    import wdt_pkg::*;
#(
    parameter int unsigned KICK_HOLD   = 8,
    parameter int unsigned LOAD_HOLD   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    input  logic        WTO,
    output logic        irq
);

    localparam int unsigned HOLD_MAX = (KICK_HOLD > LOAD_HOLD) ? KICK_HOLD : LOAD_HOLD;
    localparam int unsigned CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] KICK_CNT = CW'(KICK_HOLD);
    localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_HOLD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    wdt_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d, ie_q, ie_d, to_q, to_d;
    logic [31:0]   tocnt_q, tocnt_d;
    logic          wdlive_q, wdlive_d, irq_q, irq_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d, rdata_mux;
    logic          accept, wr_acc, rd_acc, wto_rise;
    logic          busy;

    wdt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (WTO),
        .rise_o  (wto_rise)
    );

    assign busy      = (state_q != ST_IDLE);
    assign req_ready = ~busy;
    assign accept    = req_valid & req_ready;
    assign wr_acc    = accept & req_write;
    assign rd_acc    = accept & ~req_write;

    always_comb begin
        rdata_mux = '0;
        case (req_addr)
            ADDR_CTRL: begin
                rdata_mux[CTRL_EN_BIT] = en_q;
                rdata_mux[CTRL_IE_BIT] = ie_q;
            end
            ADDR_TOCNT: rdata_mux = tocnt_q;
            ADDR_STATUS: begin
                rdata_mux[STATUS_TO_BIT]   = to_q;
                rdata_mux[STATUS_BUSY_BIT] = busy;
            end
            default: rdata_mux = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        ie_d        = ie_q;
        to_d        = to_q;
        tocnt_d     = tocnt_q;
        rsp_valid_d = rd_acc;
        rsp_rdata_d = rd_acc ? rdata_mux : rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_acc) begin
                    case (req_addr)
                        ADDR_CTRL: begin
                            en_d = req_wdata[CTRL_EN_BIT];
                            ie_d = req_wdata[CTRL_IE_BIT];
                        end
                        ADDR_KICK: begin
                            if (en_q) begin
                                state_d = ST_KICK;
                                cnt_d   = KICK_CNT;
                            end
                        end
                        ADDR_TOCNT: begin
                            tocnt_d = req_wdata;
                            state_d = ST_LOAD;
                            cnt_d   = LOAD_CNT;
                        end
                        ADDR_STATUS: begin
                            if (req_wdata[STATUS_TO_BIT]) to_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_KICK, ST_LOAD: begin
                // A count of 0 or 1 both exit, so the counter can never wrap.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Evaluated after the W1C so a coincident edge wins.
        if (wto_rise) to_d = 1'b1;

        wdlive_d = (state_d == ST_KICK);
        irq_d    = to_q & ie_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            to_q        <= 1'b0;
            tocnt_q     <= '0;
            wdlive_q    <= 1'b0;
            irq_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            ie_q        <= ie_d;
            to_q        <= to_d;
            tocnt_q     <= tocnt_d;
            wdlive_q    <= wdlive_d;
            irq_q       <= irq_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign WDEN      = en_q;
    assign WDLIVE    = wdlive_q;
    assign WTOCNT    = tocnt_q;
    assign irq       = irq_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_wdt_ctrl.sv
// Directed self-checking bench for wdt_ctrl: register access, kick/load hold
// timing, timeout capture and interrupt, and mid-sequence reset.
module tb_wdt_ctrl;
    import wdt_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        WDEN, WDLIVE, irq, WTO;
    logic [31:0] WTOCNT;

    int errors = 0;
    int checks = 0;

    wdt_ctrl #(.KICK_HOLD(8), .LOAD_HOLD(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .WDEN      (WDEN),
        .WDLIVE    (WDLIVE),
        .WTOCNT    (WTOCNT),
        .WTO       (WTO),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        wait_ready("wr");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        wait_ready(tag);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk(tag, rsp_rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst = 1'b0; WTO = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        chk("rst_wden",   32'(WDEN), 0);
        chk("rst_wdlive", 32'(WDLIVE), 0);
        chk("rst_wtocnt", WTOCNT, 0);
        chk("rst_irq",    32'(irq), 0);
        chk("rst_rspv",   32'(rsp_valid), 0);
        chk("rst_rdata",  rsp_rdata, 0);
        rst = 1'b1;
        tick();
        chk("post_rst_ready", 32'(req_ready), 1);

        // Enable then kick: 8-cycle WDLIVE pulse with the port busy
        wr(ADDR_CTRL, 32'h1);
        chk("ctrl_wden", 32'(WDEN), 1);
        chk("ctrl_no_busy", 32'(req_ready), 1);
        wr(ADDR_KICK, 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("kick_live_%0d", i), 32'(WDLIVE), 1);
            chk($sformatf("kick_notready_%0d", i), 32'(req_ready), 0);
            if (i == 4) chk("kick_busy_mid", 32'(dut.busy), 1);
            tick();
        end
        chk("kick_live_end", 32'(WDLIVE), 0);
        chk("kick_ready_end", 32'(req_ready), 1);

        // TOCNT write then back-to-back KICK held off by the load period
        wr(ADDR_TOCNT, 32'h0000_0100);
        chk("tocnt_out", WTOCNT, 32'h100);
        req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_KICK; req_wdata = '0;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("load_hold_cycles", 32'(n), 32'd8);
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        chk("b2b_kick_live", 32'(WDLIVE), 1);
        rd_chk("rd_tocnt", ADDR_TOCNT, 32'h100);
        tick();
        chk("rspv_one_cycle", 32'(rsp_valid), 0);

        // Timeout pulse -> sticky TO and interrupt
        wr(ADDR_CTRL, 32'h3);
        chk("irq_idle", 32'(irq), 0);
        WTO = 1'b1;
        tick(); tick(); tick();
        WTO = 1'b0;
        tick();
        chk("wto_irq", 32'(irq), 1);
        rd_chk("rd_status_to", ADDR_STATUS, 32'h1);
        WTO = 1'b1;
        repeat (5) tick();
        wr(ADDR_STATUS, 32'h1);
        repeat (100) tick();
        rd_chk("rd_status_held", ADDR_STATUS, 32'h0);
        chk("irq_after_w1c", 32'(irq), 0);

        // W1C coincident with a synchronized rising edge
        WTO = 1'b0;
        repeat (4) tick();
        WTO = 1'b1;
        tick(); tick(); tick();
        WTO = 1'b0;
        repeat (6) tick();
        chk("irq_before_race", 32'(irq), 1);
        WTO = 1'b1;
        tick(); tick();
        req_valid = 1'b1; req_write = 1'b1; req_addr = ADDR_STATUS; req_wdata = 32'h1;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        tick();
        chk("race_irq", 32'(irq), 1);
        rd_chk("race_status", ADDR_STATUS, 32'h1);
        chk("race_irq_after", 32'(irq), 1);
        WTO = 1'b0;

        // Kick while disabled, unmapped accesses
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_KICK, 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dis_live_%0d", i), 32'(WDLIVE), 0);
            chk($sformatf("dis_ready_%0d", i), 32'(req_ready), 1);
            tick();
        end
        rd_chk("rd_kick", ADDR_KICK, 32'h0);
        rd_chk("rd_unmapped", 4'hE, 32'h0);
        wr(4'hE, 32'hFFFF_FFFF);
        chk("unmapped_wr_norsp", 32'(rsp_valid), 0);
        rd_chk("rd_ctrl", ADDR_CTRL, 32'h0);

        // Reset in the middle of a kick pulse
        rd_chk("rd_tocnt_pre", ADDR_TOCNT, 32'h100);
        wr(ADDR_CTRL, 32'h3);
        wr(ADDR_KICK, 32'h0);
        chk("pre_rst_irq", 32'(irq), 1);
        tick(); tick();
        chk("pre_rst_live", 32'(WDLIVE), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_live",   32'(WDLIVE), 0);
        chk("mid_rst_wden",   32'(WDEN), 0);
        chk("mid_rst_wtocnt", WTOCNT, 0);
        chk("mid_rst_irq",    32'(irq), 0);
        chk("mid_rst_rspv",   32'(rsp_valid), 0);
        chk("mid_rst_rdata",  rsp_rdata, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rel_ready", 32'(req_ready), 1);
        chk("rel_busy",  32'(dut.busy), 0);
        repeat (8) tick();
        chk("rel_no_live", 32'(WDLIVE), 0);
        chk("rel_irq", 32'(irq), 0);

        // Zero is a legal TOCNT value
        wr(ADDR_TOCNT, 32'hDEAD_BEEF);
        chk("tocnt_beef", WTOCNT, 32'hDEAD_BEEF);
        wr(ADDR_TOCNT, 32'h0);
        chk("tocnt_zero", WTOCNT, 32'h0);
        rd_chk("rd_tocnt_zero", ADDR_TOCNT, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wdt_ctrl.md
WDT_CTRL -- requirements
Module: wdt_ctrl

Interface
REQ-001 SHALL have parameter KICK_HOLD, default 8, giving the number of cycles WDLIVE is held high per kick; this covers the watchdog sampling period.
REQ-002 SHALL have parameter LOAD_HOLD, default 8, giving the number of cycles a new WTOCNT is held stable before the next command is accepted.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, giving the number of flops in the WTO synchronizer.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, 1 bit: register-access request.
REQ-007 SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, 4 bits: byte address, word-aligned.
REQ-010 SHALL have port req_wdata, input, 32 bits: write data.
REQ-011 SHALL have port rsp_valid, output, 1 bit: one-cycle read-data strobe.
REQ-012 SHALL have port rsp_rdata, output, 32 bits: read data.
REQ-013 SHALL have port WDEN, output, 1 bit: watchdog enable.
REQ-014 SHALL have port WDLIVE, output, 1 bit: watchdog kick level.
REQ-015 SHALL have port WTOCNT, output, 32 bits: timeout count.
REQ-016 SHALL have port WTO, input, 1 bit: watchdog timeout; it is asynchronous to clk.
REQ-017 SHALL have port irq, output, 1 bit: timeout interrupt.

Function
REQ-018 SHALL decode the register map as follows: 0x0 CTRL (bit0 EN, bit1 IE, R/W); 0x4 KICK (write any value = kick, reads 0); 0x8 TOCNT (R/W, 32 bits); 0xC STATUS (bit0 TO, sticky, write-1-to-clear; bit1 BUSY, read-only).
REQ-019 SHALL drive WDEN = CTRL.EN and WTOCNT = the TOCNT register, both directly from flops.
REQ-020 SHALL run a state machine with states IDLE, KICK and LOAD; req_ready = 1 only in IDLE, and STATUS.BUSY = (state != IDLE).
REQ-021 SHALL, in IDLE, complete every accepted request (req_valid & req_ready) in the acceptance cycle.
REQ-022 SHALL, for a read, assert rsp_valid with rsp_rdata exactly 1 cycle after acceptance.
REQ-023 SHALL, for a read of an unmapped address, return 0.
REQ-024 SHALL ignore writes to unmapped addresses and give them no response.
REQ-025 SHALL handle a KICK write accepted in IDLE as follows: go to KICK, set WDLIVE = 1 for exactly KICK_HOLD cycles starting the next cycle, then set WDLIVE = 0 and return to IDLE.
REQ-026 SHALL handle a KICK write while CTRL.EN = 0 by completing it with no WDLIVE pulse and staying in IDLE.
REQ-027 SHALL handle a TOCNT write as follows: update the register the next cycle, go to LOAD, hold for LOAD_HOLD cycles, then return to IDLE; a value of 0 is stored unchanged.
REQ-028 SHALL apply CTRL writes in 1 cycle with no busy period.
REQ-029 SHALL NOT let a CTRL.EN clear during KICK cut the pulse short; the busy state runs to completion.
REQ-030 SHALL use a single down-counter, wide enough for max(KICK_HOLD, LOAD_HOLD), loaded on state entry; it leaves the state when the count reaches 1, and it never wraps.
REQ-031 SHALL synchronize WTO through SYNC_STAGES flops, then detect a rising edge with one more flop.
REQ-032 SHALL set STATUS.TO on a detected WTO rising edge; a WTO held high sets it only once per edge.
REQ-033 SHALL give the set priority when a W1C of STATUS.TO and a rising edge occur in the same cycle, so TO stays 1.
REQ-034 SHALL drive irq = STATUS.TO & CTRL.IE, registered, 1 cycle after the TO or IE change.

Reset
REQ-035 SHALL, on rst low, asynchronously force state = IDLE, counter = 0, CTRL = 0, TOCNT = 0, STATUS.TO = 0, and clear the synchronizer and edge flops.
REQ-036 SHALL hold all outputs low during reset: WDEN = 0, WDLIVE = 0, WTOCNT = 0, irq = 0, rsp_valid = 0, rsp_rdata = 0.
REQ-037 SHALL abort any KICK or LOAD sequence on reset mid-operation, with WDLIVE = 0 immediately and no resumption after reset.
REQ-038 SHALL release reset synchronously to clk by external design; the block adds no internal reset synchronizer.

Structure
REQ-039 SHALL take its register offsets, CTRL/STATUS bit indices and a state enum type (IDLE/KICK/LOAD) from shared package wdt_pkg.
REQ-040 SHALL contain one sub-module, wdt_sync, implementing the SYNC_STAGES synchronizer plus rising-edge detector.
REQ-041 SHALL have no other hierarchy; the total RTL is 120-400 lines.

Verification
REQ-042 SHALL cover this scenario: write CTRL=0x1, then KICK -> WDEN=1; WDLIVE high for exactly 8 cycles; req_ready low for those 8 cycles; BUSY read back as 1 mid-pulse.
REQ-043 SHALL cover this scenario: write TOCNT=0x0000_0100, then a back-to-back KICK write -> WTOCNT=0x100 on the next cycle; the KICK is not accepted for 8 cycles; the read of TOCNT returns 0x100.
REQ-044 SHALL cover this scenario: CTRL=0x3, WTO pulsed high for 3 cycles -> STATUS.TO=1 and irq=1 within SYNC_STAGES+2 cycles; WTO held high for 100 cycles after a W1C does not re-set TO.
REQ-045 SHALL cover this scenario: W1C of STATUS in the same cycle as a WTO synchronized rising edge -> STATUS reads 0x1 and irq stays 1.
REQ-046 SHALL cover this scenario: KICK with CTRL.EN=0 -> no WDLIVE pulse and req_ready stays 1; a read of 0x4 returns 0 and a read of 0xE returns 0.
REQ-047 SHALL cover this scenario: rst asserted at cycle 3 of a KICK -> WDLIVE=0 asynchronously and all outputs 0; after release, state is IDLE and req_ready=1.
